// File: rtl/input_pixel_buffer.sv
// Streams a greyscale image from SRAM as raster-order 8-bit pixels, unpacking each 32-bit word MSB byte first.
// Optional feature: define PREFETCH_EN to add a second holding word so each fetch overlaps the previous word's drain.
module input_pixel_buffer #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        start,
    input  logic [31:0] base_addr,
    output logic        rd_en,
    output logic [31:0] rd_addr,
    input  logic [31:0] rd_data,
    input  logic        rd_valid,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [7:0]  pixel,
    output logic [9:0]  col_idx,
    output logic [8:0]  row_idx,
    output logic        last,
    output logic        busy,
    output logic        img_done
);
    localparam int NWORDS = IMG_W * IMG_H / 4;
    localparam int WW     = $clog2(NWORDS + 1);
    localparam logic [WW-1:0] REQ_END = WW'(NWORDS);
    localparam logic [9:0]    COL_MAX = 10'(IMG_W - 1);
    localparam logic [8:0]    ROW_MAX = 9'(IMG_H - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

`ifdef PREFETCH_EN
    localparam logic [1:0] DEPTH = 2'd2;
`else
    localparam logic [1:0] DEPTH = 2'd1;
`endif

    logic [1:0]    state_q, state_d;
    logic [31:0]   base_q, base_d;
    logic [WW-1:0] req_q, req_d;
    logic          out_q, out_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [31:0]   hold0_q, hold0_d;
`ifdef PREFETCH_EN
    logic [31:0]   hold1_q, hold1_d;
`endif
    logic [1:0]    sub_q, sub_d;
    logic [9:0]    col_q, col_d;
    logic [8:0]    row_q, row_d;

    logic start_ok, push, pop, accept;

    // A request may only go out when nothing is in flight and a holding slot will be free for it.
    assign start_ok  = start && (state_q != S_RUN);
    assign rd_en     = (state_q == S_RUN) && !out_q && (cnt_q < DEPTH) && (req_q != REQ_END);
    assign rd_addr   = base_q + (32'(req_q) << 2);
    assign pix_valid = (cnt_q != 2'd0);
    assign accept    = pix_valid && pix_ready;
    assign pop       = accept && (sub_q == 2'd3);
    assign push      = rd_valid && out_q;
    assign last      = pix_valid && (col_q == COL_MAX) && (row_q == ROW_MAX);
    assign busy      = (state_q == S_RUN);
    assign img_done  = (state_q == S_DONE);
    assign col_idx   = col_q;
    assign row_idx   = row_q;

    always_comb begin
        case (sub_q)
            2'd0:    pixel = hold0_q[31:24];
            2'd1:    pixel = hold0_q[23:16];
            2'd2:    pixel = hold0_q[15:8];
            default: pixel = hold0_q[7:0];
        endcase
    end

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through this block infers a latch.
        state_d = state_q;
        base_d  = base_q;
        req_d   = req_q;
        out_d   = out_q;
        sub_d   = sub_q;
        col_d   = col_q;
        row_d   = row_q;
        if (start_ok) begin
            state_d = S_RUN;
            base_d  = base_addr;
            req_d   = '0;
            out_d   = 1'b0;
            sub_d   = 2'd0;
            col_d   = 10'd0;
            row_d   = 9'd0;
        end else begin
            if (state_q == S_DONE) state_d = S_IDLE;
            if (rd_en) begin
                req_d = req_q + 1'b1;
                out_d = 1'b1;
            end else if (push) begin
                out_d = 1'b0;
            end
            if (accept) begin
                sub_d = sub_q + 2'd1;
                if (last) begin
                    state_d = S_DONE;
                    col_d   = 10'd0;
                    row_d   = 9'd0;
                end else if (col_q == COL_MAX) begin
                    col_d = 10'd0;
                    row_d = row_q + 9'd1;
                end else begin
                    col_d = col_q + 10'd1;
                end
            end
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        hold0_d = hold0_q;
`ifdef PREFETCH_EN
        hold1_d = hold1_q;
`endif
        if (start_ok) begin
            cnt_d = 2'd0;
        end else begin
`ifdef PREFETCH_EN
            // hold0 is always the word being drained; hold1 queues the prefetched one.
            if (push && pop) begin
                if (cnt_q == 2'd1) begin
                    hold0_d = rd_data;
                end else begin
                    hold0_d = hold1_q;
                    hold1_d = rd_data;
                end
            end else if (push) begin
                if (cnt_q == 2'd0) hold0_d = rd_data;
                else               hold1_d = rd_data;
                cnt_d = cnt_q + 2'd1;
            end else if (pop) begin
                hold0_d = hold1_q;
                cnt_d   = cnt_q - 2'd1;
            end
`else
            if (push) begin
                hold0_d = rd_data;
                cnt_d   = 2'd1;
            end else if (pop) begin
                cnt_d = 2'd0;
            end
`endif
        end
    end

    // NOTE: the holding words are reset too, so pixel reads 0 after reset rather than X.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            req_q   <= '0;
            out_q   <= 1'b0;
            cnt_q   <= 2'd0;
            hold0_q <= '0;
`ifdef PREFETCH_EN
            hold1_q <= '0;
`endif
            sub_q   <= 2'd0;
            col_q   <= 10'd0;
            row_q   <= 9'd0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            req_q   <= req_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            hold0_q <= hold0_d;
`ifdef PREFETCH_EN
            hold1_q <= hold1_d;
`endif
            sub_q   <= sub_d;
            col_q   <= col_d;
            row_q   <= row_d;
        end
    end
endmodule
